// File: rtl/ahb_slave_mem.sv
// ----------------------------------------------------------------------------
// ahb_slave_mem
//
// An AHB-Lite style slave that fronts a small byte-wide local memory.
// It handles single NONSEQ transfers with pipelined address and data phases.
// Each data phase lasts WAIT_STATES+1 cycles: there are WAIT_STATES cycles
// with HREADY low, then one DATA cycle with HREADY high.
//
// Parameters
//   MEM_DEPTH   : number of byte locations (power of two, 2..65536)
//   WAIT_STATES : HREADY-low cycles inserted per data phase (0..7)
//
// Ports
//   HCLK       in   bus clock, all state changes on the rising edge
//   HRESETn    in   synchronous active-low reset
//   HADDR      in   [20:0] byte address, sampled in the address phase
//   HWRITE     in   1 = write, 0 = read, sampled in the address phase
//   HTRANS     in   [1:0] 2'b00 IDLE, 2'b10 NONSEQ, others illegal
//   HWDATA     in   [7:0] write data, valid in the data phase
//   HRDATA     out  [7:0] read data, valid in a read DATA cycle, held otherwise
//   HREADY     out  1 = data phase completes / address accepted this cycle
//   err_sticky out  latched on illegal HTRANS or out-of-range address
// ----------------------------------------------------------------------------
module ahb_slave_mem #(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [20:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [7:0]  HWDATA,
  output logic [7:0]  HRDATA,
  output logic        HREADY,
  output logic        err_sticky
);

  localparam int          AW            = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [2:0]  WS_LOAD       = 3'(WAIT_STATES);
  localparam bit          HAS_WAIT      = (WAIT_STATES != 0);
  localparam logic [20:0] DEPTH_LIM     = 21'(MEM_DEPTH);
  localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DATA = 2'b10
  } state_t;

  state_t          state_r;
  logic [2:0]      wait_cnt_r;
  logic [AW-1:0]   addr_r;
  logic            write_r;
  logic            in_range_r;
  logic            hready_r;
  logic [7:0]      hrdata_r;
  logic            err_r;

  logic [7:0]      mem_r [MEM_DEPTH];

  logic            accept_s;
  logic            illegal_s;
  logic            req_in_range_s;
  logic [AW-1:0]   req_idx_s;
  logic            commit_s;
  logic            fwd_s;
  logic [7:0]      rd_data_s;

  assign HREADY     = hready_r;
  assign HRDATA     = hrdata_r;
  assign err_sticky = err_r;

  // Decode the address phase and prepare zero-wait read data.
  always_comb begin
    accept_s       = 1'b0;
    illegal_s      = 1'b0;
    req_in_range_s = (HADDR < DEPTH_LIM);
    req_idx_s      = HADDR[AW-1:0];
    // A write data phase completes on any edge where the slave sits in DATA.
    commit_s       = (state_r == ST_DATA) && write_r && in_range_r;
    // A read that hits the byte being written on this same edge must see the new byte.
    fwd_s          = commit_s && (addr_r == req_idx_s);
    rd_data_s      = 8'h00;
    if (hready_r) begin
      accept_s  = (HTRANS == HTRANS_NONSEQ);
      illegal_s = (HTRANS != HTRANS_NONSEQ) && (HTRANS != HTRANS_IDLE);
    end else begin
      accept_s  = 1'b0;
      illegal_s = 1'b0;
    end
    if (!req_in_range_s) begin
      rd_data_s = 8'h00;
    end else if (fwd_s) begin
      rd_data_s = HWDATA;
    end else begin
      rd_data_s = mem_r[req_idx_s];
    end
  end

  // Transfer FSM together with its registered bus outputs and error flag.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 3'd0;
      addr_r     <= '0;
      write_r    <= 1'b0;
      in_range_r <= 1'b0;
      hready_r   <= 1'b1;
      hrdata_r   <= 8'h00;
      err_r      <= 1'b0;
    end else begin
      if (illegal_s || (accept_s && !req_in_range_s)) begin
        err_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE, ST_DATA: begin
          if (accept_s) begin
            addr_r     <= req_idx_s;
            write_r    <= HWRITE;
            in_range_r <= req_in_range_s;
            if (HAS_WAIT) begin
              state_r    <= ST_WAIT;
              wait_cnt_r <= WS_LOAD;
              hready_r   <= 1'b0;
            end else begin
              state_r    <= ST_DATA;
              wait_cnt_r <= 3'd0;
              hready_r   <= 1'b1;
              if (!HWRITE) begin
                hrdata_r <= rd_data_s;
              end
            end
          end else begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 3'd0;
            hready_r   <= 1'b1;
          end
        end
        ST_WAIT: begin
          // The counter is loaded with WAIT_STATES, so the last wait cycle is seen at 1.
          if (wait_cnt_r <= 3'd1) begin
            state_r    <= ST_DATA;
            wait_cnt_r <= 3'd0;
            hready_r   <= 1'b1;
            if (!write_r) begin
              hrdata_r <= in_range_r ? mem_r[addr_r] : 8'h00;
            end
          end else begin
            wait_cnt_r <= wait_cnt_r - 3'd1;
            hready_r   <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          wait_cnt_r <= 3'd0;
          hready_r   <= 1'b1;
        end
      endcase
    end
  end

  // Memory write port. Reset blocks the write, and the array itself is never cleared.
  always_ff @(posedge HCLK) begin
    if (HRESETn && commit_s) begin
      mem_r[addr_r] <= HWDATA;
    end
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// ----------------------------------------------------------------------------
// tb_ahb_slave_mem
//
// Three instances run with WAIT_STATES = 0, 2 and 3. A transaction-level
// model tracks, for each instance, the pending transfer, the remaining wait
// cycles and a byte memory. The outputs are compared against this model on
// every negative clock edge. Directed scenarios add literal expectations.
// ----------------------------------------------------------------------------
module tb_ahb_slave_mem;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn   [3];
  logic [20:0] haddr  [3];
  logic        hwrite [3];
  logic [1:0]  htrans [3];
  logic [7:0]  hwdata [3];
  logic [7:0]  hrdata [3];
  logic        hready [3];
  logic        err    [3];

  ahb_slave_mem #(.MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESETn(rstn[0]), .HADDR(haddr[0]), .HWRITE(hwrite[0]),
    .HTRANS(htrans[0]), .HWDATA(hwdata[0]), .HRDATA(hrdata[0]),
    .HREADY(hready[0]), .err_sticky(err[0]));

  ahb_slave_mem #(.MEM_DEPTH(256), .WAIT_STATES(2)) dut1 (
    .HCLK(clk), .HRESETn(rstn[1]), .HADDR(haddr[1]), .HWRITE(hwrite[1]),
    .HTRANS(htrans[1]), .HWDATA(hwdata[1]), .HRDATA(hrdata[1]),
    .HREADY(hready[1]), .err_sticky(err[1]));

  ahb_slave_mem #(.MEM_DEPTH(256), .WAIT_STATES(3)) dut2 (
    .HCLK(clk), .HRESETn(rstn[2]), .HADDR(haddr[2]), .HWRITE(hwrite[2]),
    .HTRANS(htrans[2]), .HWDATA(hwdata[2]), .HRDATA(hrdata[2]),
    .HREADY(hready[2]), .err_sticky(err[2]));

  int nchk = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  // ---------------- behavioural model ----------------
  logic [7:0]  mmem   [3][256];
  bit          mknown [3][256];
  bit          mrdy   [3];
  logic [7:0]  mrdata [3];
  bit          mrknown[3];
  bit          merr   [3];
  bit          pv     [3];
  bit          pw     [3];
  logic [20:0] pa     [3];
  int          wl     [3];

  function automatic int ws_of(input int d);
    case (d)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_load(input int d, input logic [20:0] a);
    if (a >= 21'd256) begin
      mrdata[d]  = 8'h00;
      mrknown[d] = 1'b1;
    end else begin
      mrdata[d]  = mmem[d][a[7:0]];
      mrknown[d] = mknown[d][a[7:0]];
    end
  endtask

  task automatic model_step(input int d);
    if (!rstn[d]) begin
      mrdata[d]  = 8'h00;
      mrknown[d] = 1'b1;
      merr[d]    = 1'b0;
      pv[d]      = 1'b0;
      wl[d]      = 0;
    end else if (pv[d] && wl[d] > 0) begin
      wl[d] = wl[d] - 1;
      if (wl[d] == 0 && !pw[d]) model_load(d, pa[d]);
    end else begin
      // The data phase finishes first, so a read accepted on this edge sees the new byte.
      if (pv[d] && pw[d] && pa[d] < 21'd256) begin
        mmem[d][pa[d][7:0]]   = hwdata[d];
        mknown[d][pa[d][7:0]] = 1'b1;
      end
      pv[d] = 1'b0;
      if (htrans[d] == 2'b10) begin
        pv[d] = 1'b1;
        pw[d] = hwrite[d];
        pa[d] = haddr[d];
        wl[d] = ws_of(d);
        if (haddr[d] >= 21'd256) merr[d] = 1'b1;
        if (wl[d] == 0 && !pw[d]) model_load(d, pa[d]);
      end else if (htrans[d] != 2'b00) begin
        merr[d] = 1'b1;
      end
    end
    mrdy[d] = !(pv[d] && wl[d] > 0);
  endtask

  initial forever begin
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_step(d);
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input int d, input logic [7:0] act, input logic [7:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, d, $time, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        check("hready", d, {7'd0, hready[d]}, {7'd0, mrdy[d]});
        check("err_sticky", d, {7'd0, err[d]}, {7'd0, merr[d]});
        if (mrknown[d]) check("hrdata", d, hrdata[d], mrdata[d]);
      end
    end
  end

  // ---------------- master tasks ----------------
  task automatic issue(input int d, input logic [1:0] tr, input logic wr,
                       input logic [20:0] a, input logic [7:0] wd);
    bit acc;
    int guard;
    htrans[d] = tr;
    hwrite[d] = wr;
    haddr[d]  = a;
    guard     = 0;
    do begin
      acc = mrdy[d];
      @(posedge clk); #1;
      guard++;
    end while (!acc && guard < 20);
    if (!acc) begin
      nchk++;
      nerr++;
      $display("FAIL issue_timeout dut%0d t=%0t: got no accept expected accept", d, $time);
    end
    hwdata[d] = wd;
    htrans[d] = 2'b00;
  endtask

  task automatic idle(input int d);
    bit acc;
    int guard;
    htrans[d] = 2'b00;
    guard     = 0;
    do begin
      acc = mrdy[d];
      @(posedge clk); #1;
      guard++;
    end while (!acc && guard < 20);
    if (!acc) begin
      nchk++;
      nerr++;
      $display("FAIL idle_timeout dut%0d t=%0t: got busy expected ready", d, $time);
    end
  endtask

  task automatic do_reset(input int d);
    htrans[d] = 2'b00;
    rstn[d]   = 1'b0;
    @(posedge clk); #1;
    rstn[d]   = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int low;
    int r;
    for (int d = 0; d < 3; d++) begin
      rstn[d] = 1'b0; haddr[d] = 21'd0; hwrite[d] = 1'b0;
      htrans[d] = 2'b00; hwdata[d] = 8'h00;
    end
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      check("rst_hready", d, {7'd0, hready[d]}, 8'h01);
      check("rst_hrdata", d, hrdata[d], 8'h00);
      check("rst_err", d, {7'd0, err[d]}, 8'h00);
      rstn[d] = 1'b1;
    end

    // Zero-wait write then back-to-back read of the same byte (forwarded).
    issue(0, 2'b10, 1'b1, 21'h10, 8'hA5);
    check("fwd_wr_hready", 0, {7'd0, hready[0]}, 8'h01);
    issue(0, 2'b10, 1'b0, 21'h10, 8'h00);
    check("fwd_rd_hready", 0, {7'd0, hready[0]}, 8'h01);
    check("fwd_rd_data", 0, hrdata[0], 8'hA5);
    idle(0);

    // Out-of-range write must not alias onto byte 0.
    issue(0, 2'b10, 1'b1, 21'h000, 8'h5A);
    issue(0, 2'b10, 1'b1, 21'h100, 8'hFF);
    issue(0, 2'b10, 1'b0, 21'h100, 8'h00);
    check("oor_rd_data", 0, hrdata[0], 8'h00);
    check("oor_err", 0, {7'd0, err[0]}, 8'h01);
    issue(0, 2'b10, 1'b0, 21'h000, 8'h00);
    check("oor_mem0", 0, hrdata[0], 8'h5A);
    idle(0);

    // Illegal HTRANS acts as idle but latches the error until reset.
    do_reset(0);
    check("ill_pre_err", 0, {7'd0, err[0]}, 8'h00);
    issue(0, 2'b11, 1'b1, 21'h000, 8'hEE);
    check("ill_hready", 0, {7'd0, hready[0]}, 8'h01);
    check("ill_err", 0, {7'd0, err[0]}, 8'h01);
    idle(0);
    issue(0, 2'b10, 1'b0, 21'h000, 8'h00);
    check("ill_mem0", 0, hrdata[0], 8'h5A);
    idle(0); idle(0); idle(0);
    check("ill_err_hold", 0, {7'd0, err[0]}, 8'h01);
    do_reset(0);
    check("ill_err_clr", 0, {7'd0, err[0]}, 8'h00);

    // Streaming: 16 writes then 16 reads with no idle cycles.
    for (int i = 0; i < 16; i++) begin
      issue(0, 2'b10, 1'b1, 21'(i), 8'(i * 17 + 1));
      check("strm_wr_hready", 0, {7'd0, hready[0]}, 8'h01);
    end
    for (int i = 0; i < 16; i++) begin
      issue(0, 2'b10, 1'b0, 21'(i), 8'h00);
      check("strm_rd_hready", 0, {7'd0, hready[0]}, 8'h01);
      check("strm_rd_data", 0, hrdata[0], 8'(i * 17 + 1));
    end
    idle(0);

    // Two wait states: exactly two HREADY-low cycles before read data.
    issue(1, 2'b10, 1'b1, 21'h3, 8'h3C);
    idle(1);
    issue(1, 2'b10, 1'b0, 21'h3, 8'h00);
    low = 0;
    for (int k = 0; k < 10; k++) begin
      if (hready[1] == 1'b1) break;
      low++;
      @(posedge clk); #1;
    end
    check("ws2_low_cycles", 1, 8'(low), 8'd2);
    check("ws2_rd_data", 1, hrdata[1], 8'h3C);
    idle(1);

    // Reset during the second wait cycle abandons the write.
    issue(2, 2'b10, 1'b1, 21'h20, 8'h11);
    idle(2);
    issue(2, 2'b10, 1'b1, 21'h20, 8'h77);
    @(posedge clk); #1;
    rstn[2] = 1'b0;
    @(posedge clk); #1;
    rstn[2] = 1'b1;
    check("rstw_hready", 2, {7'd0, hready[2]}, 8'h01);
    issue(2, 2'b10, 1'b0, 21'h20, 8'h00);
    idle(2);
    check("rstw_rd_data", 2, hrdata[2], 8'h11);

    // Randomized traffic on every instance.
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 120; n++) begin
        r = int'($urandom_range(0, 99));
        if (r < 6) begin
          issue(d, ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11, 1'($urandom_range(0, 1)),
                21'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
        end else if (r < 16) begin
          idle(d);
        end else if (r == 99) begin
          do_reset(d);
        end else begin
          issue(d, 2'b10, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) == 0) ? 21'($urandom_range(256, 2097151))
                                            : 21'($urandom_range(0, 31)),
                8'($urandom_range(0, 255)));
        end
      end
      idle(d);
    end

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/ahb_slave_mem.md
AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

Interface
REQ-001 SHALL provide parameter MEM_DEPTH, default 256, meaning byte locations in local memory (power of two, 2..65536).
REQ-002 SHALL provide parameter WAIT_STATES, default 0, meaning HREADY-low cycles inserted per data phase (0..7).
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 SHALL have port HCLK  input  1  bus clock; all state changes on rising edge.
REQ-005 SHALL have port HRESETn  input  1  synchronous active-low reset.
REQ-006 SHALL have port HADDR  input  21  byte address, sampled in the address phase.
REQ-007 SHALL have port HWRITE  input  1  1 = write, 0 = read, sampled in the address phase.
REQ-008 SHALL have port HTRANS  input  2  transfer type; 2'b00 IDLE, 2'b10 NONSEQ; 2'b01 and 2'b11 are illegal.
REQ-009 SHALL have port HWDATA  input  8  write data, valid in the data phase.
REQ-010 SHALL have port HRDATA  output  8  read data, valid when HREADY=1 in a read data phase.
REQ-011 SHALL have port HREADY  output  1  1 = current data phase completes this cycle / slave accepts an address.
REQ-012 SHALL have port err_sticky  output  1  latched flag for an illegal HTRANS or an out-of-range address.

Function
REQ-013 SHALL accept an address phase on a rising edge where HREADY=1 and HTRANS=NONSEQ, registering HADDR and HWRITE.
REQ-014 SHALL ignore HADDR, HWRITE and HTRANS on edges where HREADY=0.
REQ-015 SHALL use FSM states IDLE, WAIT and DATA: IDLE->WAIT on accept when WAIT_STATES>0; IDLE->DATA on accept when WAIT_STATES=0; WAIT->DATA after WAIT_STATES cycles; DATA->WAIT/DATA on a new accept; DATA->IDLE otherwise.
REQ-016 SHALL drive HREADY=0 in WAIT and HREADY=1 in IDLE and DATA.
REQ-017 SHALL make every data phase last exactly WAIT_STATES+1 cycles after the accepting edge, using a 3-bit wait counter that reloads on each accept.
REQ-018 SHALL write HWDATA to mem[addr] on the rising edge ending a write data phase (HREADY=1 in DATA), one write per transfer.
REQ-019 SHALL present mem[addr] on HRDATA throughout the DATA cycle of a read.
REQ-020 SHALL forward the data being written in the same edge when a read address phase to the same in-range address coincides with a write data phase completion, so the read returns the new value.
REQ-021 SHALL treat an address as in range when HADDR < MEM_DEPTH; out-of-range writes SHALL be discarded, out-of-range reads SHALL return 8'h00, and both SHALL set err_sticky with normal HREADY timing.
REQ-022 SHALL treat HTRANS 2'b01 or 2'b11 sampled with HREADY=1 as IDLE (no transfer) and set err_sticky.
REQ-023 SHALL hold HRDATA at its last value outside read data phases.
REQ-024 SHALL support back-to-back NONSEQ transfers with zero bus idle cycles (pipelined address/data overlap).
REQ-025 SHALL clear err_sticky only by reset.

Reset
REQ-026 SHALL set, when HRESETn=0 at a rising edge: state=IDLE, HREADY=1, HRDATA=8'h00, err_sticky=0, wait counter=0, pending address/control cleared.
REQ-027 SHALL abandon an in-flight transfer on reset, including a write in WAIT or DATA, which SHALL NOT be committed.
REQ-028 SHALL leave memory contents unchanged by reset; memory contents after power-up are undefined.
REQ-029 SHALL accept a NONSEQ on the first edge after HRESETn returns to 1.

Verification
REQ-030 SHALL be verified with WAIT_STATES=0: write 8'hA5 to 0x0010, then read 0x0010 back-to-back -> HREADY stays 1; HRDATA=8'hA5 in the read data cycle, forwarded.
REQ-031 SHALL be verified with WAIT_STATES=2: read 0x0003 after writing 8'h3C -> HREADY low for exactly 2 cycles, then HRDATA=8'h3C with HREADY=1.
REQ-032 SHALL be verified with an out-of-range address: write 8'hFF to 0x000100 (MEM_DEPTH=256), then read 0x000100 -> HRDATA=8'h00; err_sticky=1; mem[0x00] is unchanged.
REQ-033 SHALL be verified with an illegal transfer type: HTRANS=2'b11 with HWRITE=1 -> no memory change, state stays IDLE, err_sticky=1 until reset.
REQ-034 SHALL be verified with reset in WAIT (WAIT_STATES=3): write 8'h77 to 0x0020, assert HRESETn=0 in the 2nd wait cycle, then read 0x0020 -> the read returns the pre-existing value, not 8'h77; HREADY=1 immediately after reset.
REQ-035 SHALL be verified with a stream of 16 writes to 0x00..0x0F followed by 16 reads -> data matches and no idle gaps are needed.
